// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: valid/ready write port into a transmit FIFO feeding a
// start/data/parity/stop serializer that can also generate line breaks.
module uart_tx_stream #(
    parameter int    CLOCK_FREQ = 50_000_000,
    parameter int    BAUD_RATE  = 115_200,
    parameter int    DATA_BITS  = 8,
    parameter string PARITY     = "NONE",
    parameter int    STOP_BITS  = 1,
    parameter int    FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_BITS-1:0]            s_data,
    input  logic                            brk_req,
    output logic                            tx_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int BAUD_DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int HAS_PAR    = (PARITY == "NONE") ? 0 : 1;
    localparam int FRAME_CLKS = (1 + DATA_BITS + HAS_PAR + STOP_BITS) * BAUD_DIV;
    localparam int AW         = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);
    localparam int BW         = (BAUD_DIV > 4) ? $clog2(BAUD_DIV) : 2;
    localparam int CW         = (FRAME_CLKS > 4) ? $clog2(FRAME_CLKS) : 2;
    localparam bit PAR_OK     = (PARITY == "NONE") || (PARITY == "ODD") || (PARITY == "EVEN") ||
                                (PARITY == "MARK") || (PARITY == "SPACE");

    if (BAUD_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || !PAR_OK ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_stream: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == "ODD") return ~p;
        else if (PARITY == "EVEN") return p;
        else if (PARITY == "MARK") return 1'b1;
        else return 1'b0;
    endfunction

    state_t               state_r, state_s;
    logic [BW-1:0]        baud_r, baud_s;
    logic [3:0]           bit_r, bit_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_r, par_s;
    logic                 brk_hi_r, brk_hi_s;
    logic [CW-1:0]        brk_cnt_r, brk_cnt_s;
    logic                 tx_r, tx_s;
    logic                 busy_r;
    logic [LW-1:0]        level_r, level_s;
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head_s;
    logic                 push_s, pop_s, tick_s, empty_s, restart_s, load_s, frame_end_s;

    assign s_ready    = !rst && (level_r < LW'(FIFO_DEPTH));
    assign push_s     = s_valid && s_ready;
    assign empty_s    = (level_r == LW'(0));
    assign head_s     = mem_r[rd_ptr_r];
    assign tick_s     = (baud_r == BW'(BAUD_DIV - 1));
    assign tx_out     = tx_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;

    // Next-state and datapath decode for the serializer.
    always_comb begin
        state_s     = state_r;
        bit_s       = bit_r;
        shift_s     = shift_r;
        par_s       = par_r;
        brk_hi_s    = brk_hi_r;
        brk_cnt_s   = brk_cnt_r;
        restart_s   = 1'b0;
        load_s      = 1'b0;
        frame_end_s = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (brk_req) begin
                    state_s   = ST_BREAK;
                    brk_hi_s  = 1'b0;
                    brk_cnt_s = CW'(0);
                end else if (!empty_s) begin
                    load_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                    bit_s   = 4'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_s = shift_r >> 1;
                    if (bit_r == 4'(DATA_BITS - 1)) begin
                        state_s = (HAS_PAR != 0) ? ST_PARITY : ST_STOP;
                        bit_s   = 4'd0;
                    end else begin
                        bit_s = bit_r + 4'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_s = ST_STOP;
                    bit_s   = 4'd0;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s && bit_r == 4'(STOP_BITS - 1)) begin
                    frame_end_s = 1'b1;
                end else if (tick_s) begin
                    bit_s = bit_r + 4'd1;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (!brk_hi_r) begin
                    // Low phase lasts at least one frame and as long as brk_req stays high.
                    if (brk_cnt_r != CW'(FRAME_CLKS - 1)) begin
                        brk_cnt_s = brk_cnt_r + CW'(1);
                    end else if (!brk_req) begin
                        brk_hi_s  = 1'b1;
                        restart_s = 1'b1;
                        bit_s     = 4'd0;
                    end else begin
                        brk_cnt_s = brk_cnt_r;
                    end
                end else if (tick_s && bit_r == 4'(STOP_BITS - 1)) begin
                    frame_end_s = 1'b1;
                end else if (tick_s) begin
                    bit_s = bit_r + 4'd1;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // End of a stop/break-recovery period chains straight into the next queued word.
        if (frame_end_s) begin
            if (!empty_s && !brk_req) begin
                load_s = 1'b1;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            load_s = load_s;
        end
        if (load_s) begin
            pop_s   = 1'b1;
            state_s = ST_START;
            shift_s = head_s;
            par_s   = parity_of(head_s);
        end else begin
            pop_s = 1'b0;
        end
        if (state_s != state_r || restart_s || state_r == ST_IDLE || tick_s) begin
            baud_s = BW'(0);
        end else begin
            baud_s = baud_r + BW'(1);
        end
        if (push_s && !pop_s) begin
            level_s = level_r + LW'(1);
        end else if (pop_s && !push_s) begin
            level_s = level_r - LW'(1);
        end else begin
            level_s = level_r;
        end
    end

    // Line level for the state being entered, so tx_out changes on the transition edge.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shift_s[0];
            ST_PARITY: tx_s = par_s;
            ST_STOP:   tx_s = 1'b1;
            ST_BREAK:  tx_s = brk_hi_s;
            default:   tx_s = 1'b1;
        endcase
    end

    // State, counters, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= BW'(0);
            bit_r     <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            par_r     <= 1'b0;
            brk_hi_r  <= 1'b0;
            brk_cnt_r <= CW'(0);
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            level_r   <= LW'(0);
            wr_ptr_r  <= AW'(0);
            rd_ptr_r  <= AW'(0);
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_r     <= bit_s;
            shift_r   <= shift_s;
            par_r     <= par_s;
            brk_hi_r  <= brk_hi_s;
            brk_cnt_r <= brk_cnt_s;
            tx_r      <= tx_s;
            busy_r    <= (level_s != LW'(0)) || (state_s != ST_IDLE);
            level_r   <= level_s;
            wr_ptr_r  <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r  <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream on a 10-clock bit time: 8N1 (depth 4), 8E2 and 8O2 instances,
// with a word scoreboard checked against frames decoded from the serial lines.
module tb_uart_tx_stream;
    localparam int CF = 1_000_000;
    localparam int BR = 100_000;
    localparam int BD = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    // Edge counter used as the bench time base.
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, sv_a, brk_a, rdy_a, tx_a, busy_a;
    logic       rst_b, sv_b, brk_b, rdy_b, tx_b, busy_b;
    logic       sv_c, brk_c, rdy_c, tx_c, busy_c;
    logic [7:0] sd_a, sd_b, sd_c;
    logic [2:0] lvl_a, lvl_b, lvl_c;

    uart_tx_stream #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY("NONE"),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst_a), .s_valid(sv_a), .s_ready(rdy_a), .s_data(sd_a),
        .brk_req(brk_a), .tx_out(tx_a), .busy(busy_a), .fifo_level(lvl_a));
    uart_tx_stream #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY("EVEN"),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst_b), .s_valid(sv_b), .s_ready(rdy_b), .s_data(sd_b),
        .brk_req(brk_b), .tx_out(tx_b), .busy(busy_b), .fifo_level(lvl_b));
    uart_tx_stream #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY("ODD"),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst_b), .s_valid(sv_c), .s_ready(rdy_c), .s_data(sd_c),
        .brk_req(brk_c), .tx_out(tx_c), .busy(busy_c), .fifo_level(lvl_c));

    int n_pass = 0;
    int n_checks = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic line(input int idx);
        case (idx)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic rdy(input int idx);
        case (idx)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    // pmode: 0 none, 1 odd, 2 even
    function automatic logic model_par(input logic [7:0] d, input int pmode);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        if (pmode == 1) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    // Expected per-clock line samples starting at the accepting edge (sample 0 is still idle).
    function automatic logic [127:0] make_wave(input logic [7:0] d, input int pmode, input int nstop);
        logic [127:0] v;
        logic [11:0]  bits;
        int nb;
        v = '0;
        bits = '0;
        v[0] = 1'b1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        nb = 9;
        if (pmode != 0) begin
            bits[nb] = model_par(d, pmode);
            nb++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++)
            for (int j = 0; j < BD; j++) v[1 + b * BD + j] = bits[b];
        v[1 + nb * BD] = 1'b1;
        return v;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic capture(input int idx, input int n, output logic [127:0] v);
        v = '0;
        for (int k = 0; k < n; k++) begin
            v[k] = line(idx);
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_w(input int idx, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        case (idx)
            0:       begin sv_a = 1'b1; sd_a = d; end
            1:       begin sv_b = 1'b1; sd_b = d; end
            default: begin sv_c = 1'b1; sd_c = d; end
        endcase
        while (!rdy(idx) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", (n < 3000), 1'b1);
        case (idx)
            0:       q_a.push_back(d);
            1:       q_b.push_back(d);
            default: q_c.push_back(d);
        endcase
        @(negedge clk);
        acc = cyc;
        sv_a = 1'b0;
        sv_b = 1'b0;
        sv_c = 1'b0;
    endtask

    task automatic wait_level(input int idx, input logic lv, output int t);
        int n;
        n = 0;
        while (line(idx) !== lv && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("line_wait", (n < 5000), 1'b1);
        t = cyc;
    endtask

    task automatic rx_check(input int idx, input int pmode, input int nstop, output int t0);
        logic [7:0] d, e;
        logic p;
        int nb, sz;
        d = 8'h00;
        e = 8'h00;
        wait_level(idx, 1'b0, t0);
        wait_cyc(t0 + 5);
        check("start_bit", line(idx), 1'b0);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(t0 + BD * (1 + i) + 5);
            d[i] = line(idx);
        end
        nb = 9;
        p = 1'b0;
        if (pmode != 0) begin
            wait_cyc(t0 + BD * 9 + 5);
            p = line(idx);
            nb = 10;
        end
        for (int s = 0; s < nstop; s++) begin
            wait_cyc(t0 + BD * (nb + s) + 5);
            check("stop_bit", line(idx), 1'b1);
        end
        sz = (idx == 0) ? q_a.size() : ((idx == 1) ? q_b.size() : q_c.size());
        check("sb_pending", (sz > 0), 1'b1);
        if (sz > 0) begin
            case (idx)
                0:       e = q_a.pop_front();
                1:       e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
        end
        check("rx_data", d, e);
        if (pmode != 0) check("rx_parity", p, model_par(e, pmode));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] va, vb, vc;
        logic [7:0] w [6];
        int e0, e, t, tp, lo, hi, rb, rf, lows;

        rst_a = 1'b1; rst_b = 1'b1;
        sv_a = 1'b0; sv_b = 1'b0; sv_c = 1'b0;
        sd_a = 8'h00; sd_b = 8'h00; sd_c = 8'h00;
        brk_a = 1'b0; brk_b = 1'b0; brk_c = 1'b0;
        rf = 0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_level", lvl_a, 3'd0);
        check("rst_ready", rdy_a, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("ready_after_rst", rdy_a, 1'b1);
        @(negedge clk);

        // 8N1 single word: exact waveform including 1-clock latency and idle afterwards
        push_w(0, 8'hA5, e);
        capture(0, 102, va);
        check("wave_8n1", va, make_wave(q_a.pop_front(), 0, 1));
        check("busy_after_frame", busy_a, 1'b0);

        // 8E2 and 8O2 with 0x07
        sv_b = 1'b1; sd_b = 8'h07; sv_c = 1'b1; sd_c = 8'h07;
        check("ready_b", rdy_b, 1'b1);
        check("ready_c", rdy_c, 1'b1);
        q_b.push_back(8'h07); q_c.push_back(8'h07);
        @(negedge clk);
        sv_b = 1'b0; sv_c = 1'b0;
        fork
            capture(1, 122, vb);
            capture(2, 122, vc);
        join
        check("even_par_bit", vb[95], 1'b1);
        check("odd_par_bit", vc[95], 1'b0);
        check("wave_8e2", vb, make_wave(q_b.pop_front(), 2, 2));
        check("wave_8o2", vc, make_wave(q_c.pop_front(), 1, 2));

        // 8E2 back-to-back random words
        fork
            for (int k = 0; k < 3; k++) push_w(1, 8'($urandom_range(0, 255)), e);
            for (int k = 0; k < 3; k++) begin
                rx_check(1, 2, 2, t);
                if (k > 0) check("gap_8e2", t - tp, 120);
                tp = t;
            end
        join

        // FIFO fill with six words, full/no-bypass behaviour, contiguous frames
        for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(0, 255));
        fork
            begin
                push_w(0, w[0], e0);
                for (int k = 1; k < 5; k++) push_w(0, w[k], e);
                check("full_level", lvl_a, 3'd4);
                check("full_ready", rdy_a, 1'b0);
                fork
                    push_w(0, w[5], e);
                    begin
                        wait_cyc(e0 + 100);
                        check("full_before_pop", lvl_a, 3'd4);
                        check("ready_before_pop", rdy_a, 1'b0);
                        wait_cyc(e0 + 101);
                        check("full_pop_level", lvl_a, 3'd3);
                    end
                join
            end
            for (int k = 0; k < 6; k++) begin
                rx_check(0, 0, 1, t);
                if (k > 0) check("gap_8n1", t - tp, 100);
                tp = t;
            end
        join

        // Break requested mid-frame with words queued
        fork
            begin
                for (int k = 0; k < 3; k++) push_w(0, 8'($urandom_range(0, 255)), e);
                wait_cyc(e + 27);
                brk_a = 1'b1;
                rb = cyc;
                wait_cyc(rb + 500);
                brk_a = 1'b0;
                rf = cyc;
            end
            begin
                rx_check(0, 0, 1, tp);
                wait_level(0, 1'b0, lo);
                check("brk_start_window", (lo >= tp + 100 && lo <= tp + 101), 1'b1);
                wait_level(0, 1'b1, hi);
                check("brk_release", hi, rf + 1);
                check("brk_low_min", (hi - lo >= 100), 1'b1);
                rx_check(0, 0, 1, t);
                check("brk_high_len", t - hi, 10);
                tp = t;
                rx_check(0, 0, 1, t);
                check("gap_after_brk", t - tp, 100);
            end
        join

        // Short break from idle: low for one full frame, then one stop bit high
        wait_cyc(cyc + 5);
        brk_a = 1'b1;
        rb = cyc;
        @(negedge clk);
        check("brk_short_fall", tx_a, 1'b0);
        repeat (4) @(negedge clk);
        brk_a = 1'b0;
        wait_level(0, 1'b1, hi);
        check("brk_short_len", hi - (rb + 1), 100);
        wait_cyc(hi + 5);
        check("brk_short_busy_hi", busy_a, 1'b1);
        wait_cyc(hi + 11);
        check("brk_short_busy_end", busy_a, 1'b0);

        // Reset mid data bit with three words queued
        for (int k = 0; k < 4; k++) push_w(0, 8'h00, e);
        wait_cyc(e + 22);
        check("pre_rst_low", tx_a, 1'b0);
        check("pre_rst_level", lvl_a, 3'd3);
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", tx_a, 1'b1);
        check("rst_mid_level", lvl_a, 3'd0);
        check("rst_mid_busy", busy_a, 1'b0);
        rst_a = 1'b0;
        q_a.delete();
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            if (tx_a !== 1'b1) lows++;
            @(negedge clk);
        end
        check("no_frames_after_rst", lows, 0);
        check("idle_busy_after_rst", busy_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default "NONE", one of "NONE", "ODD", "EVEN", "MARK", "SPACE".
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries, power of 2, at least 2.
REQ-007 SHALL have port clk, input, 1, single clock, all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have port s_valid, input, 1, write request.
REQ-010 SHALL have port s_ready, output, 1, FIFO can accept a word.
REQ-011 SHALL have port s_data, input, DATA_BITS, word to send.
REQ-012 SHALL have port brk_req, input, 1, level request for a line break.
REQ-013 SHALL have port tx_out, output, 1, serial line, idle high.
REQ-014 SHALL have port busy, output, 1, FIFO non-empty or FSM not IDLE.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH+1), FIFO occupancy.

Function
REQ-016 SHALL define BAUD_DIV = CLOCK_FREQ/BAUD_RATE (integer division), and each line bit SHALL last exactly BAUD_DIV clocks.
REQ-017 SHALL stop elaboration with $error if BAUD_DIV < 4, or if DATA_BITS, STOP_BITS, PARITY or FIFO_DEPTH is illegal.
REQ-018 SHALL accept s_data on any edge where s_valid and s_ready are both 1, and SHALL write it to the FIFO tail.
REQ-019 SHALL drive s_ready = (fifo_level < FIFO_DEPTH) and not rst; a pop in the same cycle SHALL NOT raise s_ready when full (no bypass).
REQ-020 SHALL update fifo_level as +1 on push only, -1 on pop only, and unchanged when push and pop occur in the same cycle.
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-022 IDLE: if brk_req=1, SHALL go to BREAK with priority over the FIFO.
REQ-023 IDLE: else if the FIFO is non-empty, SHALL pop the head into the shift register and go to START.
REQ-024 START: 1 bit of 0, then SHALL go to DATA.
REQ-025 DATA: DATA_BITS bits, LSB first, then SHALL go to PARITY if PARITY is not "NONE", else to STOP.
REQ-026 PARITY: 1 bit; ODD SHALL make data plus parity ones count odd, EVEN SHALL make it even, MARK SHALL send 1, SPACE SHALL send 0.
REQ-027 STOP: STOP_BITS bits of 1; at the end, if the FIFO is non-empty and brk_req=0, SHALL pop and go directly to START with no idle gap, else go to IDLE.
REQ-028 tx_out SHALL be registered and reflect the next state, so tx_out falls on the same edge that pops the word in IDLE.
REQ-029 Latency: a word accepted at edge E into an empty FIFO with the FSM in IDLE SHALL produce a tx_out falling edge at E+1 clk.
REQ-030 Frame length SHALL be (1 + DATA_BITS + (PARITY!="NONE") + STOP_BITS) * BAUD_DIV clocks.
REQ-031 BREAK: tx_out SHALL be 0 for max(brk_req high time, one full frame length) and then 1 for STOP_BITS bit times before IDLE.
REQ-032 brk_req SHALL be sampled only in IDLE and at the end of STOP; a frame in flight SHALL never be truncated by brk_req.
REQ-033 The FIFO SHALL keep accepting words during BREAK and frames.
REQ-034 The baud counter SHALL restart at 0 on every state change and SHALL hold 0 in IDLE.

Reset
REQ-035 While rst=1 at an edge: FSM SHALL be IDLE, FIFO empty, fifo_level=0, tx_out=1, busy=0, s_ready=0.
REQ-036 Reset mid-frame SHALL abandon the frame, drive tx_out=1 at that edge, and discard FIFO contents.
REQ-037 s_ready SHALL go to 1 in the first cycle after rst deasserts.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, BAUD_DIV=10)
REQ-038 DATA_BITS=8, PARITY="NONE", push 0xA5 -> tx_out falls 1 clk after the push, bits 1,0,1,0,0,1,0,1 each 10 clk, stop high 10 clk, total 100 clk.
REQ-039 PARITY="EVEN", STOP_BITS=2, push 0x07 -> parity bit 1, then 20 clk high, frame 120 clk; with PARITY="ODD" -> parity bit 0.
REQ-040 FIFO_DEPTH=4, push 6 words back-to-back -> s_ready=0 once fifo_level=4, all 6 frames sent contiguously with no gap between stop and start, order preserved.
REQ-041 Push while full with a pop in the same cycle -> word not accepted, fifo_level stays 4-1=3 after that edge.
REQ-042 Raise brk_req mid-frame for 500 clk -> current frame completes, then tx_out low until brk_req falls (at least 100 clk), then 10 clk high, then queued words resume.
REQ-043 Assert rst for 1 clk mid data bit with 3 words queued -> tx_out=1 at next edge, fifo_level=0, busy=0, no further frames.
